dn_mem_sequencer: RTL and testbench

- Sequences the shared single-port program/asset memory between the HPS ioctl download stream and the running CPU.
- Buffers download bytes in a small FIFO and drives ioctl_wait for backpressure.
- Tags each byte with a memory region decoded from ioctl_index, and signals completion once the last byte is written.
- Sits between the emu top-level ioctl bus and the system's memory write port.

---
 rtl/dn_mem_pkg.sv | 21 ++
 rtl/dn_fifo.sv | 55 +++++
 rtl/dn_mem_sequencer.sv | 160 ++++++++++++++++
 tb/tb_dn_mem_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dn_mem_pkg.sv
// Shared types and constants for the ioctl download / CPU memory sequencer.
package dn_mem_pkg;

  localparam int unsigned DataW = 8;

  typedef enum logic [2:0] {
    RegionRom    = 3'd0,
    RegionChar   = 3'd1,
    RegionColour = 3'd2,
    RegionSprite = 3'd3
  } region_e;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} dn_state_e;

  // FIFO entry layout is {addr, data, region}.
  function automatic int unsigned entry_width(input int unsigned addr_w,
                                              input int unsigned region_w);
    return addr_w + DataW + region_w;
  endfunction

endpackage

// File: rtl/dn_fifo.sv
// Synchronous FIFO with simultaneous push/pop, occupancy count and drop-on-full flag.
module dn_fifo #(
  parameter int unsigned Width = 28,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic [Width-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [Width-1:0]           o_rdata,
  output logic [$clog2(Depth+1)-1:0] o_count,
  output logic [$clog2(Depth+1)-1:0] o_count_nxt,
  output logic                       o_empty,
  output logic                       o_accept,
  output logic                       o_drop
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_full;
  logic             w_pop;

  assign o_empty     = (r_count == '0);
  assign w_full      = (r_count == CntW'(Depth));
  assign w_pop       = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push on a full FIFO is still taken.
  assign o_accept    = i_push && (!w_full || w_pop);
  assign o_drop      = i_push && !o_accept;
  assign o_count     = r_count;
  assign o_count_nxt = r_count + CntW'(o_accept) - CntW'(w_pop);
  assign o_rdata     = r_mem[r_rptr];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (o_accept) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)    r_rptr <= r_rptr + PtrW'(1);
      r_count <= o_count_nxt;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (o_accept) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/dn_mem_sequencer.sv
// Arbitrates the shared memory port between buffered ioctl download bytes and CPU accesses.
module dn_mem_sequencer
  import dn_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 15,
  parameter int unsigned REGION_W   = 3
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [DataW-1:0]    ioctl_dout,
  input  logic [7:0]          ioctl_index,
  output logic                ioctl_wait,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DataW-1:0]    cpu_din,
  input  logic [REGION_W-1:0] cpu_region,
  output logic                cpu_ack,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DataW-1:0]    mem_din,
  output logic                mem_we,
  output logic [REGION_W-1:0] mem_region,
  output logic                dn_busy,
  output logic                dn_done,
  output logic                dn_overflow
);

  localparam int unsigned EntryW = entry_width(ADDR_W, REGION_W);
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StrvW  = $clog2(STARVE_MAX + 1);

  logic [EntryW-1:0]   w_wdata;
  logic [EntryW-1:0]   w_rdata;
  logic [CntW-1:0]     w_count;
  logic [CntW-1:0]     w_count_nxt;
  logic                w_push;
  logic                w_accept;
  logic                w_drop;
  logic                w_empty;
  logic                w_full;
  logic                w_force;
  logic                w_cpu_gnt;
  logic                w_dn_gnt;
  logic                w_drained;
  logic                w_unused;
  dn_state_e           r_state;
  dn_state_e           w_state_nxt;
  logic [StrvW-1:0]    r_starve;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DataW-1:0]    r_mem_din;
  logic [REGION_W-1:0] r_mem_region;
  logic                r_mem_we;
  logic                r_cpu_ack;
  logic                r_dn_wr;
  logic                r_wait;
  logic                r_busy;
  logic                r_done;
  logic                r_overflow;

  assign w_push  = ioctl_wr && ioctl_download;
  assign w_wdata = {ioctl_addr[ADDR_W-1:0], ioctl_dout, ioctl_index[REGION_W-1:0]};
  // Upper address/index bits are intentionally discarded.
  assign w_unused = ^{ioctl_addr[24:ADDR_W], ioctl_index[7:REGION_W]};

  dn_fifo #(
    .Width(EntryW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .i_push     (w_push),
    .i_wdata    (w_wdata),
    .i_pop      (w_dn_gnt),
    .o_rdata    (w_rdata),
    .o_count    (w_count),
    .o_count_nxt(w_count_nxt),
    .o_empty    (w_empty),
    .o_accept   (w_accept),
    .o_drop     (w_drop)
  );

  assign w_full    = (w_count == CntW'(FIFO_DEPTH));
  assign w_force   = (r_starve == StrvW'(STARVE_MAX));
  assign w_cpu_gnt = cpu_req && !w_force;
  assign w_dn_gnt  = !w_empty && !w_cpu_gnt;
  // Drained once the FIFO is empty and the last download write has left the port.
  assign w_drained = w_empty && !r_dn_wr;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nxt = StLoad;
      StLoad:  if (!ioctl_download) w_state_nxt = w_drained ? StDone : StDrain;
      StDrain: begin
        if (ioctl_download)  w_state_nxt = StLoad;
        else if (w_drained)  w_state_nxt = StDone;
      end
      StDone:  w_state_nxt = w_accept ? StLoad : StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_starve     <= '0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_mem_region <= '0;
      r_mem_we     <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_dn_wr      <= 1'b0;
      r_wait       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_mem_we  <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_dn_wr   <= w_dn_gnt;
      if (w_cpu_gnt) begin
        r_mem_addr   <= cpu_addr;
        r_mem_din    <= cpu_din;
        r_mem_region <= cpu_region;
        r_mem_we     <= cpu_we;
        r_cpu_ack    <= 1'b1;
      end else if (w_dn_gnt) begin
        {r_mem_addr, r_mem_din, r_mem_region} <= w_rdata;
        r_mem_we <= 1'b1;
      end
      if (w_dn_gnt)                r_starve <= '0;
      else if (w_full && w_cpu_gnt) r_starve <= r_starve + StrvW'(1);
      // One slot of slack for the strobe already in flight when wait is seen.
      r_wait     <= (w_count_nxt >= CntW'(FIFO_DEPTH - 1));
      r_busy     <= (w_state_nxt == StLoad) || (w_state_nxt == StDrain);
      r_done     <= (w_state_nxt == StDone);
      r_overflow <= r_overflow || w_drop;
    end
  end

  assign ioctl_wait  = r_wait;
  assign cpu_ack     = r_cpu_ack;
  assign mem_addr    = r_mem_addr;
  assign mem_din     = r_mem_din;
  assign mem_we      = r_mem_we;
  assign mem_region  = r_mem_region;
  assign dn_busy     = r_busy;
  assign dn_done     = r_done;
  assign dn_overflow = r_overflow;

endmodule

// File: tb/tb_dn_mem_sequencer.sv
// Scoreboard bench for dn_mem_sequencer: stimulus queues expected writes, a monitor checks them.
module tb_dn_mem_sequencer;
  import dn_mem_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wait;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [16:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [2:0]  cpu_region = '0;
  logic        cpu_ack;
  logic [16:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [2:0]  mem_region;
  logic        dn_busy;
  logic        dn_done;
  logic        dn_overflow;

  typedef struct packed {
    logic [16:0] a;
    logic [7:0]  d;
    logic [2:0]  r;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  n_we = 0;
  int  n_done = 0;
  int  last_we_cyc = 0;
  int  last_done_cyc = 0;
  bit  wait_seen = 1'b0;

  dn_mem_sequencer dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_index   (ioctl_index),
    .ioctl_wait    (ioctl_wait),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_din       (cpu_din),
    .cpu_region    (cpu_region),
    .cpu_ack       (cpu_ack),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_we        (mem_we),
    .mem_region    (mem_region),
    .dn_busy       (dn_busy),
    .dn_done       (dn_done),
    .dn_overflow   (dn_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  // Write-port monitor: every mem_we must match the head of the expected queue.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (ioctl_wait) wait_seen = 1'b1;
      if (dn_done) begin
        n_done++;
        last_done_cyc = cyc;
      end
      if (mem_we) begin
        n_we++;
        last_we_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_we: got addr 0x%0h data 0x%0h, want no write",
                   mem_addr, mem_din);
        end else begin
          mon_e = exp_q.pop_front();
          chk("we_addr", 32'(mem_addr), 32'(mon_e.a));
          chk("we_data", 32'(mem_din), 32'(mon_e.d));
          chk("we_region", 32'(mem_region), 32'(mon_e.r));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic exp_push(input logic [16:0] a, input logic [7:0] d, input logic [2:0] r);
    wr_t e;
    e.a = a;
    e.d = d;
    e.r = r;
    exp_q.push_back(e);
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx);
    ioctl_wr    = 1'b1;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_index = idx;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_done(input int base, input string name);
    for (int i = 0; i < 30; i++) begin
      if (n_done > base) break;
      tick();
    end
    chk(name, 32'(n_done > base), 32'd1);
  endtask

  task automatic cpu_access(input logic we, input logic [16:0] a, input logic [7:0] d,
                            input logic [2:0] r, input string name);
    bit got;
    got = 1'b0;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_din = d;
    cpu_region = r;
    if (we) exp_push(a, d, r);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_ack) begin
        got = 1'b1;
        break;
      end
    end
    cpu_req = 1'b0;
    chk({name, "_ack"}, 32'(got), 32'd1);
    chk({name, "_we"}, 32'(mem_we), 32'(we));
    chk({name, "_addr"}, 32'(mem_addr), 32'(a));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish before 200us");
    $fatal(1);
  end

  initial begin
    int base_we;
    int base_done;
    int n_acks;

    // Reset state
    repeat (3) tick();
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_busy_done_ovf", 32'({dn_busy, dn_done, dn_overflow, cpu_ack}), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // CPU write and read on an idle download path
    cpu_access(1'b1, 17'h01234, 8'hA5, RegionColour, "cpu_wr");
    cpu_access(1'b0, 17'h00042, 8'h00, RegionRom, "cpu_rd");

    // 8 spaced download bytes, idle CPU
    base_we = n_we;
    base_done = n_done;
    wait_seen = 1'b0;
    ioctl_download = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_push(17'(i), 8'h10 + 8'(i), RegionChar);
      strobe(25'(i), 8'h10 + 8'(i), 8'h01);
      if (i == 0) chk("lat_push_edge", 32'(mem_we), 32'd0);
      if (i == 7) begin
        ioctl_download = 1'b0;
        chk("t1_busy", 32'(dn_busy), 32'd1);
      end else begin
        tick();
        if (i == 0) chk("lat_two_cycles", 32'(mem_we), 32'd1);
        repeat (2) tick();
      end
    end
    wait_done(base_done, "t1_done_seen");
    repeat (3) tick();
    chk("t1_we_count", 32'(n_we - base_we), 32'd8);
    chk("t1_done_count", 32'(n_done - base_done), 32'd1);
    chk("t1_done_delay", 32'(last_done_cyc - last_we_cyc), 32'd2);
    chk("t1_wait_never", 32'(wait_seen), 32'd0);
    chk("t1_busy_clear", 32'(dn_busy), 32'd0);

    // Burst under CPU load: wait threshold and starvation escape
    base_we = n_we;
    base_done = n_done;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_push(17'h00100 + 17'(i), 8'h20 + 8'(i), RegionSprite);
      strobe(25'h100 + 25'(i), 8'h20 + 8'(i), 8'h03);
      chk("t2_wait_level", 32'(ioctl_wait), 32'(i >= 2));
    end
    n_acks = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_we) break;
      if (cpu_ack) n_acks++;
    end
    chk("t2_forced_we", 32'(mem_we), 32'd1);
    chk("t2_forced_no_ack", 32'(cpu_ack), 32'd0);
    chk("t2_starve_grants", 32'(n_acks), 32'd15);
    cpu_req = 1'b0;
    for (int i = 4; i < 6; i++) begin
      for (int k = 0; k < 20 && ioctl_wait; k++) tick();
      chk("t2_wait_fall", 32'(ioctl_wait), 32'd0);
      exp_push(17'h00100 + 17'(i), 8'h20 + 8'(i), RegionSprite);
      strobe(25'h100 + 25'(i), 8'h20 + 8'(i), 8'h03);
    end
    ioctl_download = 1'b0;
    wait_done(base_done, "t2_done_seen");
    repeat (3) tick();
    chk("t2_we_count", 32'(n_we - base_we), 32'd6);

    // Strobes ignoring wait overflow the FIFO
    base_we = n_we;
    base_done = n_done;
    cpu_req = 1'b1;
    ioctl_download = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_push(17'h00200 + 17'(i), 8'h40 + 8'(i), RegionColour);
      strobe(25'h200 + 25'(i), 8'h40 + 8'(i), 8'h0A);
      if (i == 3) chk("t3_no_ovf_yet", 32'(dn_overflow), 32'd0);
      if (i == 4) chk("t3_ovf_set", 32'(dn_overflow), 32'd1);
    end
    cpu_req = 1'b0;
    ioctl_download = 1'b0;
    wait_done(base_done, "t3_done_seen");
    repeat (3) tick();
    chk("t3_we_count", 32'(n_we - base_we), 32'd4);
    chk("t3_ovf_sticky", 32'(dn_overflow), 32'd1);

    // Address truncation to 17 bits
    base_we = n_we;
    base_done = n_done;
    ioctl_download = 1'b1;
    exp_push(17'h00000, 8'h5A, RegionSprite);
    strobe(25'h0020000, 8'h5A, 8'h03);
    exp_push(17'h1FFFF, 8'hA5, RegionSprite);
    strobe(25'h001FFFF, 8'hA5, 8'h03);
    exp_push(17'h03456, 8'h3C, RegionRom);
    strobe(25'h0123456, 8'h3C, 8'h00);
    ioctl_download = 1'b0;
    wait_done(base_done, "t4_done_seen");
    repeat (3) tick();
    chk("t4_we_count", 32'(n_we - base_we), 32'd3);

    // Download drops, reasserts, drops again with bytes queued
    base_we = n_we;
    base_done = n_done;
    cpu_req = 1'b1;
    ioctl_download = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_push(17'h00300 + 17'(i), 8'h60 + 8'(i), RegionChar);
      strobe(25'h300 + 25'(i), 8'h60 + 8'(i), 8'h01);
    end
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
    chk("t5_busy_held", 32'(dn_busy), 32'd1);
    chk("t5_no_early_done", 32'(n_done - base_done), 32'd0);
    ioctl_download = 1'b0;
    cpu_req = 1'b0;
    wait_done(base_done, "t5_done_seen");
    repeat (4) tick();
    chk("t5_done_count", 32'(n_done - base_done), 32'd1);
    chk("t5_we_count", 32'(n_we - base_we), 32'd3);

    // Asynchronous reset with entries queued
    base_we = n_we;
    base_done = n_done;
    cpu_req = 1'b1;
    ioctl_download = 1'b1;
    strobe(25'h400, 8'h77, 8'h02);
    strobe(25'h401, 8'h78, 8'h02);
    chk("t6_pre_ack", 32'(cpu_ack), 32'd1);
    chk("t6_pre_busy", 32'(dn_busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_ctrl", 32'({cpu_ack, mem_we, ioctl_wait, dn_busy, dn_done, dn_overflow}), 32'd0);
    chk("t6_rst_data", 32'({mem_addr, mem_din, mem_region}), 32'd0);
    cpu_req = 1'b0;
    ioctl_download = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    chk("t6_no_we", 32'(n_we - base_we), 32'd0);
    chk("t6_no_done", 32'(n_done - base_done), 32'd0);
    chk("t6_ovf_clear", 32'(dn_overflow), 32'd0);
    chk("t6_busy_clear", 32'(dn_busy), 32'd0);

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
